// File: rtl/led_stepper_pkg.sv
// led_stepper_pkg: shared state, mode and direction encodings for the LED pattern stepper
package led_stepper_pkg;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEFT   = 3'd1,
    S_RIGHT  = 3'd2,
    S_BOUNCE = 3'd3,
    S_FLASH  = 3'd4
  } state_t;
  typedef enum logic [1:0] {
    MODE_LEFT   = 2'd0,
    MODE_RIGHT  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_FLASH  = 2'd3
  } mode_t;
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  function automatic state_t mode_state(input mode_t m);
    return m == MODE_LEFT ? S_LEFT : m == MODE_RIGHT ? S_RIGHT : m == MODE_BOUNCE ? S_BOUNCE : S_FLASH;
  endfunction
endpackage

// File: rtl/led_pattern_stepper_if.sv
// led_pattern_stepper_if: tick/mode inputs and LED/wrap/state outputs of the stepper
interface led_pattern_stepper_if #(
  parameter int NB_LEDS  = 4,
  parameter int NB_MODE  = 2,
  parameter int NB_STATE = 3
);
  logic                i_valid;
  logic                i_enable;
  logic [NB_MODE-1:0]  i_mode;
  logic [NB_LEDS-1:0]  o_led;
  logic                o_wrap;
  logic [NB_STATE-1:0] o_state;
  modport master (output i_valid, i_enable, i_mode, input o_led, o_wrap, o_state);
  modport slave  (input i_valid, i_enable, i_mode, output o_led, o_wrap, o_state);
endinterface

// File: rtl/valid_edge_detect.sv
// valid_edge_detect: one-cycle pulse on the rising edge of i_sig
module valid_edge_detect (
  input  logic clock,
  input  logic i_reset,
  input  logic i_sig,
  output logic o_rise
);
  logic valid_d;
  always_ff @(posedge clock or negedge i_reset)
    if (!i_reset) valid_d <= 1'b0;
    else valid_d <= i_sig;
  assign o_rise = i_sig & ~valid_d;
endmodule

// File: rtl/led_pattern_stepper.sv
// led_pattern_stepper: mode-selected LED pattern FSM advanced by qualified rate ticks
// LED_STEPPER_VALID_EDGE_EN: step only on the rising edge of i_valid instead of every high cycle
module led_pattern_stepper
  import led_stepper_pkg::*;
#(
  parameter int NB_LEDS  = 4,
  parameter int NB_MODE  = 2,
  parameter int NB_STATE = 3
) (
  input logic clock,
  input logic i_reset,
  led_pattern_stepper_if.slave bus
);
  state_t state, state_n, tgt;
  logic [NB_LEDS-1:0] led, led_n, seed;
  logic [NB_MODE-1:0] mode_raw;
  logic dir, dir_n, wrap, wrap_n, tick, step, reload, adv;
`ifdef LED_STEPPER_VALID_EDGE_EN
  valid_edge_detect u_edge (
    .clock  (clock),
    .i_reset(i_reset),
    .i_sig  (bus.i_valid),
    .o_rise (tick)
  );
`else
  assign tick = bus.i_valid;
`endif
  assign mode_raw = bus.i_mode;
  assign tgt      = mode_state(mode_t'(mode_raw[1:0]));
  assign step     = tick & bus.i_enable;
  // a mode change (or leaving idle) only loads the seed; shifting starts on the next step
  assign reload   = step && (state == S_IDLE || state != tgt);
  assign adv      = step && !reload;
  assign seed     = (tgt == S_LEFT || tgt == S_BOUNCE) ? NB_LEDS'(1) :
                    tgt == S_RIGHT ? {1'b1, {(NB_LEDS-1){1'b0}}} : '1;
  always_comb begin
    state_n = state;
    led_n   = led;
    dir_n   = dir;
    wrap_n  = 1'b0;
    case (state)
      S_IDLE: begin end
      S_LEFT: if (adv) begin
        led_n  = {led[NB_LEDS-2:0], led[NB_LEDS-1]};
        wrap_n = led[NB_LEDS-1];
      end
      S_RIGHT: if (adv) begin
        led_n  = {led[0], led[NB_LEDS-1:1]};
        wrap_n = led[0];
      end
      S_BOUNCE: if (adv) begin
        led_n  = dir == DIR_LEFT ? led << 1 : led >> 1;
        dir_n  = dir == DIR_LEFT ? (led[NB_LEDS-2] ? DIR_RIGHT : DIR_LEFT) : (led[1] ? DIR_LEFT : DIR_RIGHT);
        wrap_n = dir == DIR_RIGHT && led[1];
      end
      S_FLASH: if (adv) begin
        led_n  = ~led;
        wrap_n = ~|led;
      end
      default: begin
        state_n = S_IDLE;
        led_n   = '0;
        dir_n   = DIR_LEFT;
      end
    endcase
    if (reload && state <= S_FLASH) begin
      state_n = tgt;
      led_n   = seed;
      dir_n   = DIR_LEFT;
    end
  end
  always_ff @(posedge clock or negedge i_reset)
    if (!i_reset) begin
      state <= S_IDLE;
      led   <= '0;
      dir   <= DIR_LEFT;
      wrap  <= 1'b0;
    end else begin
      state <= state_n;
      led   <= led_n;
      dir   <= dir_n;
      wrap  <= wrap_n;
    end
  assign bus.o_led   = led;
  assign bus.o_wrap  = wrap;
  assign bus.o_state = NB_STATE'(state);
endmodule

// File: tb/tb_led_pattern_stepper.sv
// tb_led_pattern_stepper: directed test plan plus randomized stimulus against a position-based model
module tb_led_pattern_stepper;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int passes = 0;
  int wrap_cnt = 0;
  bit chk_en = 1'b0;
  led_pattern_stepper_if #(.NB_LEDS(N), .NB_MODE(2), .NB_STATE(3)) bus ();
  led_pattern_stepper #(.NB_LEDS(N), .NB_MODE(2), .NB_STATE(3)) dut (
    .clock  (clk),
    .i_reset(rst_n),
    .bus    (bus)
  );
  always #5 clk = ~clk;
  // model: pattern kept as a lit position / flash phase rather than a shifting vector
  int m_st = 0;
  int m_pos = 0;
  bit m_right = 1'b0;
  bit m_on = 1'b0;
  bit m_wrap = 1'b0;
`ifdef LED_STEPPER_VALID_EDGE_EN
  bit m_vd = 1'b0;
`endif
  task automatic model_step();
    int want;
    bit tk;
    if (!rst_n) begin
      m_st = 0; m_pos = 0; m_right = 0; m_on = 0; m_wrap = 0;
`ifdef LED_STEPPER_VALID_EDGE_EN
      m_vd = 0;
`endif
      return;
    end
    tk = bus.i_valid;
`ifdef LED_STEPPER_VALID_EDGE_EN
    tk = bus.i_valid && !m_vd;
    m_vd = bus.i_valid;
`endif
    m_wrap = 0;
    if (!(tk && bus.i_enable)) return;
    want = int'(bus.i_mode) + 1;
    if (m_st == 0 || want != m_st) begin
      m_st = want; m_pos = (want == 2) ? N - 1 : 0; m_right = 0; m_on = 1;
    end else if (m_st == 1) begin
      m_wrap = (m_pos == N - 1); m_pos = (m_pos + 1) % N;
    end else if (m_st == 2) begin
      m_wrap = (m_pos == 0); m_pos = (m_pos + N - 1) % N;
    end else if (m_st == 3) begin
      m_pos = m_right ? m_pos - 1 : m_pos + 1;
      if (m_pos == N - 1) m_right = 1;
      if (m_pos == 0) begin m_right = 0; m_wrap = 1; end
    end else begin
      m_wrap = !m_on; m_on = !m_on;
    end
  endtask
  function automatic logic [N-1:0] exp_led();
    if (m_st == 0) return '0;
    if (m_st == 4) return m_on ? '1 : '0;
    return N'(1 << m_pos);
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    else passes++;
  endtask
  task automatic pin(input string name, input logic [N-1:0] l, input logic w, input int st);
    chk({name, " led"}, 32'(bus.o_led), 32'(l));
    chk({name, " model led"}, 32'(exp_led()), 32'(l));
    chk({name, " wrap"}, 32'(bus.o_wrap), 32'(w));
    chk({name, " state"}, 32'(bus.o_state), st);
  endtask
  task automatic tick1();
    @(posedge clk); #2 bus.i_valid = 1'b1;
    @(posedge clk); #2 bus.i_valid = 1'b0;
    @(negedge clk);
  endtask
  task automatic do_reset();
    @(posedge clk); #2 rst_n = 1'b0; bus.i_valid = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
  endtask
  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("cycle led", 32'(bus.o_led), 32'(exp_led()));
      chk("cycle wrap", 32'(bus.o_wrap), 32'(m_wrap));
      chk("cycle state", 32'(bus.o_state), m_st);
      if (bus.o_wrap) wrap_cnt++;
    end
  end
  initial begin
    bus.i_valid = 1'b0; bus.i_enable = 1'b1; bus.i_mode = 2'b00;
    #1 rst_n = 1'b0;
    #20 chk_en = 1'b1;
    do_reset();
    pin("reset", 4'b0000, 0, 0);
    tick1(); pin("left1", 4'b0001, 0, 1);
    tick1(); pin("left2", 4'b0010, 0, 1);
    tick1(); pin("left3", 4'b0100, 0, 1);
    tick1(); pin("left4", 4'b1000, 0, 1);
    tick1(); pin("left5", 4'b0001, 1, 1);
    do_reset(); bus.i_mode = 2'b10;
    tick1(); pin("bnc1", 4'b0001, 0, 3);
    tick1(); pin("bnc2", 4'b0010, 0, 3);
    tick1(); pin("bnc3", 4'b0100, 0, 3);
    tick1(); pin("bnc4", 4'b1000, 0, 3);
    tick1(); pin("bnc5", 4'b0100, 0, 3);
    tick1(); pin("bnc6", 4'b0010, 0, 3);
    tick1(); pin("bnc7", 4'b0001, 1, 3);
    do_reset(); bus.i_mode = 2'b00;
    repeat (3) tick1();
    pin("left at 0100", 4'b0100, 0, 1);
    bus.i_mode = 2'b11;
    tick1(); pin("flash1", 4'b1111, 0, 4);
    tick1(); pin("flash2", 4'b0000, 0, 4);
    tick1(); pin("flash3", 4'b1111, 1, 4);
    do_reset(); bus.i_mode = 2'b01;
    tick1(); pin("right1", 4'b1000, 0, 2);
    tick1(); pin("right2", 4'b0100, 0, 2);
    bus.i_enable = 1'b0; bus.i_mode = 2'b10;
    repeat (3) tick1();
    pin("frozen", 4'b0100, 0, 2);
    bus.i_enable = 1'b1; bus.i_mode = 2'b01;
    tick1(); pin("thawed", 4'b0010, 0, 2);
    do_reset(); bus.i_mode = 2'b10;
    repeat (4) tick1();
    pin("bnc top", 4'b1000, 0, 3);
    @(posedge clk); #2 rst_n = 1'b0;
    #1 pin("async rst", 4'b0000, 0, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    tick1(); pin("post rst seed", 4'b0001, 0, 3);
    do_reset(); bus.i_mode = 2'b00;
    @(posedge clk); #2 wrap_cnt = 0; bus.i_valid = 1'b1;
    repeat (6) @(posedge clk);
    #2 bus.i_valid = 1'b0;
    @(negedge clk);
`ifdef LED_STEPPER_VALID_EDGE_EN
    pin("hold6", 4'b0001, 0, 1);
    chk("hold6 wraps", 32'(wrap_cnt), 0);
    tick1(); pin("second edge", 4'b0010, 0, 1);
`else
    pin("hold6", 4'b0010, 0, 1);
    chk("hold6 wraps", 32'(wrap_cnt), 1);
`endif
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
      bus.i_valid = 1'($urandom_range(0, 1));
      bus.i_enable = $urandom_range(0, 4) != 0;
      if ($urandom_range(0, 9) == 0) bus.i_mode = 2'($urandom_range(0, 3));
    end
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/led_pattern_stepper.md
Name: led_pattern_stepper

Overview:
- Downstream consumer of the rate-tick counter's `o_valid`. Each qualified tick advances an LED pattern by one step.
- Pattern behaviour comes from a mode-selected state machine: rotate left, rotate right, bounce, or flash.
- Drives the board LEDs. Also produces a one-cycle wrap pulse for later stages, for example a pass counter.

Parameters:
- NB_LEDS, default 4: LED vector width; legal values are ≥2.
- NB_MODE, default 2: mode select width; fixed at 2, other values are not supported.
- NB_STATE, default 3: width of the state encoding exported on `o_state`.

Ports:
- clock  in  1  system clock; all flops are clocked on the rising edge.
- i_reset  in  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to `clock`.
- i_valid  in  1  rate tick from the upstream counter.
- i_enable  in  1  step enable; when low, the block is frozen.
- i_mode  in  NB_MODE  00 rotate-left, 01 rotate-right, 10 bounce, 11 flash.
- o_led  out  NB_LEDS  registered LED pattern.
- o_wrap  out  1  registered one-cycle pulse at the end of a pattern pass.
- o_state  out  NB_STATE  current FSM state, for debug.

Behaviour:
- Reset (i_reset=0):
  - state=S_IDLE, o_led=0, o_wrap=0, bounce direction=left.
  - Takes effect asynchronously, including in the middle of a pass; no partial pattern survives.
- Step qualifier: step = tick & i_enable, where tick = i_valid, or rising edge of i_valid when the optional feature is enabled.
- Updates happen only on step cycles:
  - o_led/state change at the clock edge that samples step=1, visible the next cycle (latency 1).
  - o_wrap is high for exactly one cycle, that same next cycle; otherwise it is 0.
- i_enable=0: o_led, state and direction hold; o_wrap=0; i_mode is ignored.
- States: S_IDLE, S_LEFT, S_RIGHT, S_BOUNCE, S_FLASH.
- Mode sampling: i_mode is sampled only on step.
  - If the mode differs from the current state, or state=S_IDLE, move to the mode's state and load its seed on that step. No shift and no wrap occur on that step.
  - Seeds: LEFT = bit0 one-hot; RIGHT = bit NB_LEDS-1 one-hot; BOUNCE = bit0 with direction=left; FLASH = all ones.
- S_LEFT:
  - Rotate left by 1.
  - The step moving bit NB_LEDS-1 → bit0 raises o_wrap.
- S_RIGHT:
  - Rotate right by 1.
  - The step moving bit0 → bit NB_LEDS-1 raises o_wrap.
- S_BOUNCE:
  - Shift in the current direction; no rotation.
  - At bit NB_LEDS-1 the direction flips to right, so the next step goes to bit NB_LEDS-2; the MSB is never held for two steps.
  - At bit0 while moving right, the direction flips to left and o_wrap is raised on the step that arrives at bit0.
  - Pass length is 2·(NB_LEDS-1) steps.
- S_FLASH:
  - o_led toggles between all ones and all zeros.
  - The zeros→ones step raises o_wrap.
- o_led is always one-hot in S_LEFT, S_RIGHT and S_BOUNCE, and uniform in S_FLASH.
- Any unreachable state encoding recovers to S_IDLE on the next clock with o_led=0.

Optional Feature:
- Macro: LED_STEPPER_VALID_EDGE_EN.
- Defined:
  - Adds a valid_d flop (reset 0); tick = i_valid & ~valid_d.
  - An upstream `o_valid` held high (upstream counter paused) produces exactly one step.
  - valid_d updates every cycle regardless of i_enable.
- Undefined:
  - tick = i_valid; every high cycle is a step.
  - No extra flop.

Decomposition:
- Shared package, led_stepper_pkg:
  - State localparams S_IDLE=0, S_LEFT=1, S_RIGHT=2, S_BOUNCE=3, S_FLASH=4.
  - Mode codes MODE_LEFT/RIGHT/BOUNCE/FLASH.
  - Direction codes DIR_LEFT=0, DIR_RIGHT=1.
- Sub-module valid_edge_detect (clock, i_reset, i_sig, o_rise), instantiated only under the macro.
- The FSM and pattern datapath remain a single module.

Test Plan (NB_LEDS=4):
- Reset, then i_mode=00, i_enable=1, five single-cycle i_valid pulses → o_led 0001, 0010, 0100, 1000, 0001; o_wrap is high only after the fifth pulse.
- i_mode=10, seven ticks from IDLE → 0001, 0010, 0100, 1000, 0100, 0010, 0001; o_wrap is high after the seventh tick only.
- In S_LEFT at 0100, set i_mode=11 and tick → 1111, no wrap. Next ticks → 0000, then 1111 with o_wrap=1.
- In S_RIGHT at 0100, drop i_enable, pulse i_valid 3 times and change i_mode → o_led stays 0100 and o_state stays S_RIGHT. Raise i_enable and tick → 0010.
- Mid-bounce at 1000 moving right, assert i_reset low between clock edges → o_led=0000, o_wrap=0 and o_state=S_IDLE immediately. After release, the first tick loads the mode's seed.
- Macro defined, i_mode=00, hold i_valid high for 6 cycles → exactly one step (0001); a second rising edge → 0010. Macro undefined, same stimulus → 6 steps ending at 0010, with o_wrap pulsing once.
